// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HALT  = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // "finish: j finish" -- a j whose pseudo-direct target is its own address
  function automatic logic is_self_jump(input logic [31:0] instr, input logic [31:0] pc);
    return (instr[31:26] == OP_J) && ({pc[31:28], instr[25:0], 2'b00} == pc);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM read port, decode handshake and redirect request seen by the fetch unit.
interface fetch_sequencer_if;
  logic [31:0] ReadAddr;
  logic [31:0] Instr;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic [31:0] InstrPC4;
  logic        InstrValid;
  logic        InstrReady;
  logic        RedirectValid;
  logic [31:0] RedirectAddr;

  modport master (
    output ReadAddr, InstrOut, InstrPC, InstrPC4, InstrValid,
    input  Instr, InstrReady, RedirectValid, RedirectAddr
  );

  modport slave (
    input  ReadAddr, InstrOut, InstrPC, InstrPC4, InstrValid,
    output Instr, InstrReady, RedirectValid, RedirectAddr
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch buffer of {pc, instr}; flush overrides push and pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  fq_entry_t                       din,
  output fq_entry_t                       dout,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(QDEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  fq_entry_t     r_mem [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr = push && !flush;
  assign w_rd = pop && !flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= ptr_inc(r_tail);
      if (w_rd) r_head <= ptr_inc(r_head);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_head];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(QDEPTH));

  pop_not_empty: assert property (@(posedge clk) disable iff (!rst_n) !(w_rd && empty));

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch controller: feeds the queue from the ROM, handles redirects, halt and fault.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32,
  parameter int          QDEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus,
  output logic               Halted,
  output logic               Fault
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam int          CW        = $clog2(QDEPTH + 1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;

  fq_entry_t     w_q_head;
  logic          w_q_full;
  logic          w_q_empty;
  logic [CW-1:0] w_q_count;

  logic w_redirect, w_redirect_bad, w_valid, w_pop, w_fetch_try, w_pc_bad, w_push, w_flush;

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_redirect     = bus.RedirectValid && (r_state != FS_FAULT);
    w_redirect_bad = (bus.RedirectAddr[1:0] != 2'b00) || (bus.RedirectAddr >= MEM_BYTES);
    w_valid        = !w_q_empty && (r_state != FS_FAULT);
    w_pop          = w_valid && bus.InstrReady && !w_redirect;
    // a same-cycle pop frees the slot the fetched word is about to take
    w_fetch_try    = (r_state == FS_FETCH) && !w_redirect && (!w_q_full || w_pop);
    w_pc_bad       = (r_pc >= MEM_BYTES);
    w_push         = w_fetch_try && !w_pc_bad;
    w_flush        = w_redirect || (w_fetch_try && w_pc_bad);

    if (w_redirect) begin
      w_pc_next    = bus.RedirectAddr;
      w_state_next = w_redirect_bad ? FS_FAULT : FS_FETCH;
    end else if (w_fetch_try && w_pc_bad) begin
      w_state_next = FS_FAULT;
    end else if (w_push) begin
      w_pc_next = r_pc + 32'd4;
      if (is_self_jump(bus.Instr, r_pc)) w_state_next = FS_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FS_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ('{pc: r_pc, instr: bus.Instr}),
    .dout  (w_q_head),
    .full  (w_q_full),
    .empty (w_q_empty),
    .count (w_q_count)
  );

  assign bus.ReadAddr   = r_pc;
  assign bus.InstrValid = w_valid;
  assign bus.InstrOut   = (w_q_count != '0) ? w_q_head.instr : 32'h0;
  assign bus.InstrPC    = (w_q_count != '0) ? w_q_head.pc : 32'h0;
  assign bus.InstrPC4   = (w_q_count != '0) ? w_q_head.pc + 32'd4 : 32'h0;
  assign Halted         = (r_state == FS_HALT);
  assign Fault          = (r_state == FS_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: cycle table of inputs/expected outputs plus throughput and redirect-latency sequences.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic Halted;
  logic Fault;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (32),
    .QDEPTH    (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .Halted (Halted),
    .Fault  (Fault)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [32];
  always_comb bus.Instr = (bus.ReadAddr < 32'd128) ? rom[bus.ReadAddr[6:2]] : 32'h0;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_raddr;
    logic        chk_raddr;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void v(input logic r, input logic y, input logic rvi, input logic [31:0] rai,
                            input logic ev, input logic [31:0] ep, input logic [31:0] ei,
                            input logic [31:0] er, input logic cr, input logic eh, input logic ef);
    vec_t t;
    t.rst_n = r;  t.rdy = y;  t.rv = rvi;  t.ra = rai;
    t.e_valid = ev;  t.e_pc = ep;  t.e_instr = ei;  t.e_raddr = er;
    t.chk_raddr = cr;  t.e_halt = eh;  t.e_fault = ef;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic y, input logic rvi, input logic [31:0] rai);
    rst_n             = r;
    bus.InstrReady    = y;
    bus.RedirectValid = rvi;
    bus.RedirectAddr  = rai;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n;

    for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | 32'(i);
    rom[0]  = 32'h3c010000;
    rom[1]  = 32'h34240050;
    rom[2]  = 32'h20050004;
    rom[23] = 32'h08000017;
    rom[24] = 32'h00004020;

    // boot stream
    v(0,1,0,32'h00, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,1,0,32'h00, 1,32'h00,32'h3c010000, 32'h04,1,0,0);
    v(1,1,0,32'h00, 1,32'h04,32'h34240050, 32'h08,1,0,0);
    v(1,1,0,32'h00, 1,32'h08,32'h20050004, 32'h0c,1,0,0);
    // backpressure from reset
    v(0,0,0,32'h00, 1,32'h0c,32'h20000003, 32'h10,1,0,0);
    v(1,0,0,32'h00, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,0,0,32'h00, 1,32'h00,32'h3c010000, 32'h04,1,0,0);
    v(1,0,0,32'h00, 1,32'h00,32'h3c010000, 32'h08,1,0,0);
    v(1,0,0,32'h00, 1,32'h00,32'h3c010000, 32'h08,1,0,0);
    v(1,1,0,32'h00, 1,32'h00,32'h3c010000, 32'h08,1,0,0);
    v(1,1,0,32'h00, 1,32'h04,32'h34240050, 32'h0c,1,0,0);
    v(1,1,0,32'h00, 1,32'h08,32'h20050004, 32'h10,1,0,0);
    // redirect with a full queue
    v(1,0,0,32'h00, 1,32'h0c,32'h20000003, 32'h14,1,0,0);
    v(1,0,1,32'h60, 1,32'h0c,32'h20000003, 32'h14,1,0,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h60,1,0,0);
    v(1,1,0,32'h00, 1,32'h60,32'h00004020, 32'h64,1,0,0);
    v(1,1,0,32'h00, 1,32'h64,32'h20000019, 32'h68,1,0,0);
    // halt on self-jump, then redirect out of it
    v(1,1,1,32'h5c, 1,32'h68,32'h2000001a, 32'h6c,1,0,0);
    v(1,0,0,32'h00, 0,32'h00,32'h0,        32'h5c,1,0,0);
    v(1,0,0,32'h00, 1,32'h5c,32'h08000017, 32'h60,1,1,0);
    v(1,0,0,32'h00, 1,32'h5c,32'h08000017, 32'h60,1,1,0);
    v(1,1,0,32'h00, 1,32'h5c,32'h08000017, 32'h60,1,1,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h60,1,1,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h60,1,1,0);
    v(1,1,1,32'h00, 0,32'h00,32'h0,        32'h60,1,1,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,1,0,32'h00, 1,32'h00,32'h3c010000, 32'h04,1,0,0);
    // misaligned redirect faults; later redirect ignored
    v(1,1,1,32'h22, 1,32'h04,32'h34240050, 32'h08,1,0,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,0,0,1);
    v(1,1,1,32'h60, 0,32'h00,32'h0,        32'h00,0,0,1);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,0,0,1);
    // last legal word, then range fault at 0x80
    v(0,1,0,32'h00, 0,32'h00,32'h0,        32'h00,0,0,1);
    v(1,1,1,32'h7c, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h7c,1,0,0);
    v(1,1,0,32'h00, 1,32'h7c,32'h2000001f, 32'h80,1,0,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,0,0,1);
    // reset while halted with one entry and a redirect pending
    v(0,0,0,32'h00, 0,32'h00,32'h0,        32'h00,0,0,1);
    v(1,0,1,32'h5c, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,0,0,32'h00, 0,32'h00,32'h0,        32'h5c,1,0,0);
    v(1,0,0,32'h00, 1,32'h5c,32'h08000017, 32'h60,1,1,0);
    v(0,0,1,32'h60, 1,32'h5c,32'h08000017, 32'h60,1,1,0);
    v(1,1,0,32'h00, 0,32'h00,32'h0,        32'h00,1,0,0);
    v(1,1,0,32'h00, 1,32'h00,32'h3c010000, 32'h04,1,0,0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst_n, vq[i].rdy, vq[i].rv, vq[i].ra);
      #1;
      $display("step %0d rst_n=%b rdy=%b rv=%b ra=%h | valid=%b pc=%h instr=%h raddr=%h halted=%b fault=%b",
               i, vq[i].rst_n, vq[i].rdy, vq[i].rv, vq[i].ra, bus.InstrValid, bus.InstrPC,
               bus.InstrOut, bus.ReadAddr, Halted, Fault);
      chk("valid",  i, 32'(bus.InstrValid), 32'(vq[i].e_valid));
      chk("pc",     i, bus.InstrPC, vq[i].e_pc);
      chk("instr",  i, bus.InstrOut, vq[i].e_instr);
      chk("pc4",    i, bus.InstrPC4, vq[i].e_valid ? vq[i].e_pc + 32'd4 : 32'h0);
      chk("halted", i, 32'(Halted), 32'(vq[i].e_halt));
      chk("fault",  i, 32'(Fault), 32'(vq[i].e_fault));
      if (vq[i].chk_raddr) chk("raddr", i, bus.ReadAddr, vq[i].e_raddr);
    end

    // sustained one-per-cycle delivery continuing from the last table step
    exp_pc = 32'h04;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      #1;
      $display("stream %0d valid=%b pc=%h instr=%h", k, bus.InstrValid, bus.InstrPC, bus.InstrOut);
      chk("stream_valid", k, 32'(bus.InstrValid), 32'd1);
      chk("stream_pc",    k, bus.InstrPC, exp_pc);
      chk("stream_instr", k, bus.InstrOut, rom[exp_pc[6:2]]);
      exp_pc = exp_pc + 32'd4;
    end

    // redirect bubble: head appears exactly one cycle after the bubble cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h10);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("bubble_valid", 0, 32'(bus.InstrValid), 32'd0);
    n = 0;
    while (!bus.InstrValid && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    $display("redirect latency %0d pc=%h instr=%h", n, bus.InstrPC, bus.InstrOut);
    chk("redir_latency", 0, 32'(n), 32'd1);
    chk("redir_pc",      0, bus.InstrPC, 32'h10);
    chk("redir_instr",   0, bus.InstrOut, 32'h20000004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
